// File: rtl/noc_pkg.sv
// noc_pkg: router-wide constants and allocator state type shared by crossbar, route compute and allocator
package noc_pkg;
  localparam int NUM_PORTS = 5;
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'd5;
  localparam int FLIT_W = 8;
  typedef enum logic {ST_IDLE, ST_LOCKED} alloc_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: 5-request round-robin arbiter, first request at or after i_ptr wins
// i_req: request vector; i_ptr: search start (0..4)
// o_gnt: one-hot winner (zero when no request); o_idx: encoded winner
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SEL_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [SEL_W-1:0]     o_idx
);
  logic [SEL_W-1:0] w_j;
  // Search backwards so the last hit written is the first one in cyclic order.
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_j = SEL_W'((32'(i_ptr) + k) % NUM_PORTS);
      if (i_req[w_j]) o_idx = w_j;
    end
  end
  assign o_gnt = |i_req ? NUM_PORTS'(1) << o_idx : '0;
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin allocation with wormhole locking for the 5-port router
// clk, rst_n (async active-low); req/dest/tail per input (L,N,E,W,S = 0..4, dest 3 bits each)
// out_ready per output; grant per input; out_valid per output; Select_<o> crossbar selects (5 = idle)
// Optional: SW_ALLOC_TIMEOUT_EN releases a lock after TIMEOUT stalled cycles.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [SEL_W*NUM_PORTS-1:0] dest,
  input  logic [NUM_PORTS-1:0]       tail,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS-1:0]       grant,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [SEL_W-1:0]           Select_L,
  output logic [SEL_W-1:0]           Select_N,
  output logic [SEL_W-1:0]           Select_E,
  output logic [SEL_W-1:0]           Select_W,
  output logic [SEL_W-1:0]           Select_S
);
  alloc_state_e [NUM_PORTS-1:0]                r_state;
  logic [NUM_PORTS-1:0][SEL_W-1:0]             r_owner;
  logic [NUM_PORTS-1:0][SEL_W-1:0]             r_ptr;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]         w_cand;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]         w_gnt;
  logic [NUM_PORTS-1:0][SEL_W-1:0]             w_win;
  logic [NUM_PORTS-1:0][SEL_W-1:0]             w_sel;
  logic [NUM_PORTS-1:0]                        w_lock;
  logic [NUM_PORTS-1:0]                        w_busy;
  logic [NUM_PORTS-1:0]                        w_go;
  logic [NUM_PORTS-1:0]                        w_taken;
  logic [NUM_PORTS-1:0]                        w_rel;
  logic [NUM_PORTS-1:0]                        w_to;
  always_comb begin
    w_busy = '0;
    grant = '0;
    out_valid = '0;
    w_rel = '0;
    w_lock = '0;
    w_sel = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_lock[o] = r_state[o] == ST_LOCKED;
      w_sel[o] = w_lock[o] ? r_owner[o] : SEL_IDLE;
      out_valid[o] = w_lock[o] & req[r_owner[o]] & out_ready[o];
      w_rel[o] = out_valid[o] & tail[r_owner[o]];
      if (w_lock[o]) begin
        w_busy[r_owner[o]] = 1'b1;
        grant[r_owner[o]] = grant[r_owner[o]] | out_ready[o];
      end
    end
  end
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cand
      assign w_cand[o][p] = req[p] & (dest[SEL_W*p +: SEL_W] == SEL_W'(o)) & ~w_busy[p];
    end
    rr_arbiter u_arb (
      .i_req(w_cand[o]),
      .i_ptr(r_ptr[o]),
      .o_gnt(w_gnt[o]),
      .o_idx(w_win[o])
    );
  end
  // An input claimed by a lower-numbered output in the same cycle is withheld from higher ones.
  always_comb begin
    w_taken = '0;
    w_go = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_go[o] = ~w_lock[o] & |(w_gnt[o] & ~w_taken);
      w_taken = w_taken | w_gnt[o];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_go[o]) begin
          r_state[o] <= ST_LOCKED;
          r_owner[o] <= w_win[o];
        end else if (w_lock[o] && (w_rel[o] || w_to[o])) begin
          r_state[o] <= ST_IDLE;
          r_ptr[o] <= r_owner[o] == SEL_W'(NUM_PORTS - 1) ? '0 : r_owner[o] + 1'b1;
        end
      end
    end
  end
`ifdef SW_ALLOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [NUM_PORTS-1:0][CNT_W-1:0] r_cnt;
  // The stall that brings the count to TIMEOUT releases the lock at the same edge.
  always_comb begin
    w_to = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      w_to[o] = w_lock[o] & ~out_valid[o] & (r_cnt[o] == CNT_W'(TIMEOUT - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++)
        r_cnt[o] <= (!w_lock[o] || out_valid[o] || w_to[o]) ? '0 : r_cnt[o] + 1'b1;
    end
  end
`else
  assign w_to = '0;
`endif
  assign Select_L = w_sel[PORT_L];
  assign Select_N = w_sel[PORT_N];
  assign Select_E = w_sel[PORT_E];
  assign Select_W = w_sel[PORT_W];
  assign Select_S = w_sel[PORT_S];
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed checks of locking, round-robin, backpressure, parallel locks and async reset
module tb_switch_allocator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] req, tail, out_ready, grant, out_valid;
  logic [14:0] dest;
  logic [2:0] sel_l, sel_n, sel_e, sel_w, sel_s;
  int n_run = 0;
  int n_fail = 0;
  int n_pulse;
`ifdef SW_ALLOC_TIMEOUT_EN
  localparam int TO_EXP = 5;
`else
  localparam int TO_EXP = 1;
`endif
  always #5 clk = ~clk;
  switch_allocator dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dest(dest), .tail(tail), .out_ready(out_ready),
    .grant(grant), .out_valid(out_valid),
    .Select_L(sel_l), .Select_N(sel_n), .Select_E(sel_e), .Select_W(sel_w), .Select_S(sel_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_selL"}, 32'(sel_l), 5);
    chk({tag, "_selN"}, 32'(sel_n), 5);
    chk({tag, "_selE"}, 32'(sel_e), 5);
    chk({tag, "_selW"}, 32'(sel_w), 5);
    chk({tag, "_selS"}, 32'(sel_s), 5);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
  endtask
  function automatic logic [14:0] d(input int p, input int o);
    return 15'(o) << (3 * p);
  endfunction
  initial begin
    req = '0; dest = '0; tail = '0; out_ready = 5'h1f;
    #3;
    chk_idle("reset");
    tick;
    rst_n = 1'b1;
    req = 5'b00001; dest = d(0, 2);
    #1;
    chk("pre_lock_grant", 32'(grant), 0);
    tick;
    chk("lock_selE", 32'(sel_e), 0);
    chk("lock_grant", 32'(grant), 5'b00001);
    chk("lock_valid", 32'(out_valid), 5'b00100);
    out_ready = 5'b11011;
    #1;
    chk("notready_grant", 32'(grant), 0);
    chk("notready_valid", 32'(out_valid), 0);
    out_ready = 5'h1f; tail = 5'b00001;
    tick;
    chk("tail_selE", 32'(sel_e), 5);
    chk("bubble_grant", 32'(grant), 0);
    req = 5'b11010; dest = d(1, 2) | d(3, 2) | d(4, 2); tail = 5'b11010;
    tick;
    chk("rr1_selE", 32'(sel_e), 1);
    chk("rr1_grant", 32'(grant), 5'b00010);
    tick;
    chk("rr1_bubble", 32'(sel_e), 5);
    req = 5'b11000;
    tick;
    chk("rr2_selE", 32'(sel_e), 3);
    chk("rr2_grant", 32'(grant), 5'b01000);
    tick;
    chk("rr2_bubble", 32'(sel_e), 5);
    req = 5'b10000;
    tick;
    chk("rr3_selE", 32'(sel_e), 4);
    chk("rr3_grant", 32'(grant), 5'b10000);
    tick;
    chk("rr3_bubble", 32'(sel_e), 5);
    req = 5'b00001; dest = d(0, 1); tail = '0;
    tick;
    chk("bp_lock_selN", 32'(sel_n), 0);
    out_ready = 5'b11101;
    for (int i = 0; i < 4; i++) begin
      req = i < 2 ? 5'b00001 : 5'b00000;
      #1;
      chk("bp_grant", 32'(grant), 0);
      chk("bp_valid", 32'(out_valid), 0);
      tick;
      chk("bp_hold_selN", 32'(sel_n), 0);
    end
    req = 5'b00001; out_ready = 5'h1f; n_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      tail = i == 2 ? 5'b00001 : 5'b00000;
      #1;
      n_pulse += int'(out_valid[1]);
      tick;
    end
    chk("bp_pulses", 32'(n_pulse), 3);
    chk("bp_release_selN", 32'(sel_n), 5);
    req = 5'b00101; dest = d(0, 4) | d(2, 3); tail = '0;
    tick;
    chk("par_selS", 32'(sel_s), 0);
    chk("par_selW", 32'(sel_w), 2);
    chk("par_grant", 32'(grant), 5'b00101);
    tail = 5'b00001;
    tick;
    chk("par_relS", 32'(sel_s), 5);
    chk("par_keepW", 32'(sel_w), 2);
    req = 5'b00100; tail = 5'b00100;
    tick;
    chk("par_relW", 32'(sel_w), 5);
    req = 5'b00001; dest = d(0, 6); tail = '0;
    tick;
    tick;
    chk_idle("bad_dest");
    req = 5'b00010; dest = d(1, 0);
    tick;
    chk("to_lock_selL", 32'(sel_l), 1);
    req = '0;
    repeat (15) tick;
    chk("to_15_selL", 32'(sel_l), 1);
    tick;
    chk("to_16_selL", 32'(sel_l), TO_EXP);
    req = 5'b00001; dest = d(0, 3);
    tick;
    chk("arst_lock_selW", 32'(sel_w), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    tick;
    rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
